// File: rtl/unsharp_mask_frame_ctrl.sv
// Frame sequencer for the unsharp-mask kernel.
// Loads img RAM, runs the kernel, drains mask_img RAM.
module unsharp_mask_frame_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int NUM_PIXELS  = 1024,
  parameter int RUN_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err,
  output logic              ap_start,
  input  logic              ap_done,
  input  logic              ap_idle,
  input  logic              k_img_ce,
  input  logic [ADDR_W-1:0] k_img_addr,
  output logic [DATA_W-1:0] k_img_q,
  input  logic              k_mask_ce,
  input  logic              k_mask_we,
  input  logic [ADDR_W-1:0] k_mask_addr,
  input  logic [DATA_W-1:0] k_mask_d,
  output logic              img_ce,
  output logic              img_we,
  output logic [ADDR_W-1:0] img_addr,
  output logic [DATA_W-1:0] img_d,
  input  logic [DATA_W-1:0] img_q,
  output logic              mask_ce,
  output logic              mask_we,
  output logic [ADDR_W-1:0] mask_addr,
  output logic [DATA_W-1:0] mask_d,
  input  logic [DATA_W-1:0] mask_q
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] NPIX = CW'(NUM_PIXELS);
  localparam logic [CW-1:0] LAST = CW'(NUM_PIXELS - 1);
  localparam logic [31:0] TO_LAST = 32'(RUN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] rcnt;
  logic [CW-1:0] ocnt;
  logic [31:0]   run_cnt;
  logic          rd_pend;

  logic in_fire;
  logic out_fire;
  logic rd_issue;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign rd_issue = (state == S_DRAIN) && (rcnt < NPIX)
                 && (!out_valid || out_ready);

  // Last beat of the frame is flagged as it is accepted.
  assign frame_done = out_fire && (ocnt == LAST);

  // Frame sequencer with registered handshake outputs.
  // A read landing on a stalled output register is dropped
  // and its address re-read, so one register suffices.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      rcnt        <= '0;
      ocnt        <= '0;
      run_cnt     <= '0;
      rd_pend     <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      ap_start    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && ap_idle) begin
            state    <= S_LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            wcnt     <= '0;
          end
        end
        S_LOAD: begin
          if (in_fire) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == LAST) begin
              state    <= S_START;
              in_ready <= 1'b0;
              ap_start <= 1'b1;
            end
          end
        end
        S_START: begin
          if (!ap_idle) begin
            state    <= S_RUN;
            ap_start <= 1'b0;
            run_cnt  <= '0;
          end
        end
        S_RUN: begin
          if (ap_done) begin
            state   <= S_DRAIN;
            rcnt    <= '0;
            ocnt    <= '0;
            rd_pend <= 1'b0;
          end else if (RUN_TIMEOUT != 0
                       && run_cnt == TO_LAST) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          rd_pend <= rd_issue;
          if (rd_issue) begin
            rcnt <= rcnt + 1'b1;
          end
          if (rd_pend) begin
            if (!out_valid || out_ready) begin
              out_data  <= mask_q;
              out_valid <= 1'b1;
            end else begin
              rcnt <= rcnt - 1'b1;
            end
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
          if (out_fire) begin
            ocnt <= ocnt + 1'b1;
            if (ocnt == LAST) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              rd_pend   <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM port ownership: controller outside RUN, kernel in RUN.
  always_comb begin
    img_ce    = 1'b0;
    img_we    = 1'b0;
    img_addr  = '0;
    img_d     = '0;
    k_img_q   = '0;
    mask_ce   = 1'b0;
    mask_we   = 1'b0;
    mask_addr = '0;
    mask_d    = '0;
    case (state)
      S_LOAD: begin
        img_ce   = in_fire;
        img_we   = in_fire;
        img_addr = wcnt[ADDR_W-1:0];
        img_d    = in_data;
      end
      S_RUN: begin
        img_ce    = k_img_ce;
        img_addr  = k_img_addr;
        k_img_q   = img_q;
        mask_ce   = k_mask_ce;
        mask_we   = k_mask_we;
        mask_addr = k_mask_addr;
        mask_d    = k_mask_d;
      end
      S_DRAIN: begin
        mask_ce   = 1'b1;
        mask_addr = rcnt[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unsharp_mask_frame_ctrl.sv
// Bench for unsharp_mask_frame_ctrl: RAM and kernel models,
// scoreboard of expected output words, separate monitor.
module tb_unsharp_mask_frame_ctrl;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic          frame_done;
  logic          timeout_err;
  logic          ap_start;
  logic          ap_done;
  logic          ap_idle;
  logic          k_img_ce;
  logic [AW-1:0] k_img_addr;
  logic [DW-1:0] k_img_q;
  logic          k_mask_ce;
  logic          k_mask_we;
  logic [AW-1:0] k_mask_addr;
  logic [DW-1:0] k_mask_d;
  logic          img_ce;
  logic          img_we;
  logic [AW-1:0] img_addr;
  logic [DW-1:0] img_d;
  logic [DW-1:0] img_q;
  logic          mask_ce;
  logic          mask_we;
  logic [AW-1:0] mask_addr;
  logic [DW-1:0] mask_d;
  logic [DW-1:0] mask_q;

  unsharp_mask_frame_ctrl #(
    .ADDR_W(AW), .DATA_W(DW),
    .NUM_PIXELS(N), .RUN_TIMEOUT(50)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err),
    .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle),
    .k_img_ce(k_img_ce), .k_img_addr(k_img_addr),
    .k_img_q(k_img_q),
    .k_mask_ce(k_mask_ce), .k_mask_we(k_mask_we),
    .k_mask_addr(k_mask_addr), .k_mask_d(k_mask_d),
    .img_ce(img_ce), .img_we(img_we),
    .img_addr(img_addr), .img_d(img_d),
    .img_q(img_q),
    .mask_ce(mask_ce), .mask_we(mask_we),
    .mask_addr(mask_addr), .mask_d(mask_d),
    .mask_q(mask_q)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk_eq(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference kernel transform: mask[i] = 3*img[i] + const
  function automatic logic [31:0] kf(input logic [31:0] x);
    return x * 32'd3 + 32'h1234_0007;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM models (1-cycle read) ----------
  logic [DW-1:0] img_mem  [N];
  logic [DW-1:0] mask_mem [N];
  logic [DW-1:0] pre_val  [N];
  bit            preload_req = 1'b0;

  always @(posedge clk)
    if (img_ce) begin
      if (img_we) img_mem[img_addr] <= img_d;
      img_q <= img_mem[img_addr];
    end

  always @(posedge clk)
    if (preload_req) begin
      for (int i = 0; i < N; i++) mask_mem[i] <= pre_val[i];
    end else if (mask_ce) begin
      if (mask_we) mask_mem[mask_addr] <= mask_d;
      mask_q <= mask_mem[mask_addr];
    end

  // ---------------- kernel model -----------------------
  logic        krun;
  int          kc;
  int          done_at = 20;
  bit          kwr     = 1'b0;
  bit          kabort  = 1'b0;
  logic [31:0] nz;

  always @(posedge clk) nz <= $urandom;

  always @(posedge clk) begin
    if (!rst || kabort) begin
      krun <= 1'b0; ap_idle <= 1'b1; kc <= 0;
    end else if (!krun) begin
      if (ap_start && ap_idle) begin
        krun <= 1'b1; ap_idle <= 1'b0; kc <= 0;
      end
    end else begin
      kc <= kc + 1;
      if (done_at != 0 && kc == done_at) begin
        krun <= 1'b0; ap_idle <= 1'b1;
      end
    end
  end

  // Reads img[kc-2], writes mask[kc-3]; noise when idle.
  always_comb begin
    ap_done     = krun && done_at != 0 && kc == done_at;
    k_img_ce    = nz[0];
    k_mask_ce   = nz[1];
    k_mask_we   = nz[2];
    k_img_addr  = nz[4:3];
    k_mask_addr = nz[6:5];
    k_mask_d    = ~nz;
    if (krun) begin
      k_img_ce    = kc >= 2 && kc < 2 + N;
      k_img_addr  = AW'(kc - 2);
      k_mask_ce   = kwr && kc >= 3 && kc < 3 + N;
      k_mask_we   = k_mask_ce;
      k_mask_addr = AW'(kc - 3);
      k_mask_d    = kf(k_img_q);
    end
  end

  // ---------------- out_ready driver -------------------
  bit rnd_ready   = 1'b0;
  bit ready_fixed = 1'b1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      else out_ready = ready_fixed;
    end
  end

  // ---------------- scoreboard monitor -----------------
  logic [DW-1:0] sb [$];
  int            acc_cyc [$];
  int            wr_cyc [$];
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  bit            log_en = 1'b0;
  int            beat_idx = 0;
  bit            hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic [DW-1:0] exp_w;

  always @(negedge clk) begin
    if (!rst) begin
      beat_idx = 0;
      hold_v   = 1'b0;
    end else begin
      if (hold_v && out_valid)
        chk_eq("stall_stable", out_data, hold_d);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk_eq("unexpected_beat", out_data, 32'hx);
        end else begin
          exp_w = sb.pop_front();
          chk_eq("out_data", out_data, exp_w);
        end
        chk_eq("frame_done", frame_done,
               32'(beat_idx == N - 1));
        acc_cyc.push_back(cyc);
        beat_idx = (beat_idx == N - 1) ? 0 : beat_idx + 1;
      end else if (frame_done) begin
        chk_eq("spurious_frame_done", frame_done, 0);
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      if (ap_idle) begin
        chk_eq("idle_img_ce", img_ce, in_valid && in_ready);
        chk_eq("idle_mask_we", mask_we, 0);
        chk_eq("idle_k_img_q", k_img_q, 0);
      end
      if (krun && kc >= 1 && busy) begin
        chk_eq("run_img_ce", img_ce, k_img_ce);
        chk_eq("run_img_we", img_we, 0);
        chk_eq("run_k_img_q", k_img_q, img_q);
        chk_eq("run_mask_ce", mask_ce, k_mask_ce);
        chk_eq("run_mask_we", mask_we, k_mask_we);
        if (k_img_ce)
          chk_eq("run_img_addr", img_addr, k_img_addr);
        if (k_mask_ce) begin
          chk_eq("run_mask_addr", mask_addr, k_mask_addr);
          chk_eq("run_mask_d", mask_d, k_mask_d);
        end
      end
      if (log_en && img_ce && img_we && ap_idle) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(img_addr);
        wr_data.push_back(img_d);
      end
    end
  end

  // ---------------- stimulus tasks ---------------------
  task automatic send_frame(input logic [DW-1:0] v [N]);
    int  i = 0;
    int  t = 0;
    bit  fire;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = v[0];
    while (i < N && t < 100) begin
      @(negedge clk);
      fire = in_ready;
      @(posedge clk);
      #1;
      t++;
      if (fire) begin
        i++;
        if (i < N) in_data = v[i];
      end
    end
    in_valid = 1'b0;
    chk_eq("load_beats", i, N);
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((sb.size() != 0 || busy) && t < 500);
    chk_eq("frame_end_busy", busy, 0);
    chk_eq("frame_end_sb", sb.size(), 0);
  endtask

  task automatic chk_reset_outs();
    chk_eq("rst_ctrl",
           {in_ready, out_valid, busy, frame_done,
            timeout_err, ap_start, img_ce, img_we,
            mask_ce, mask_we}, 0);
    chk_eq("rst_out_data", out_data, 0);
    chk_eq("rst_k_img_q", k_img_q, 0);
  endtask

  task automatic rand_frame(output logic [DW-1:0] v [N],
                            input bit push);
    for (int i = 0; i < N; i++) begin
      v[i] = $urandom;
      if (push) sb.push_back(kf(v[i]));
    end
  endtask

  // ---------------- main sequence ----------------------
  logic [DW-1:0] fv [N];
  int            ap_cyc;
  int            t;
  int            run_cycles;

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs();
    @(posedge clk);
    #1 rst = 1'b1;

    // Frame A: known data, preloaded mask, kernel not writing
    for (int i = 0; i < N; i++) begin
      pre_val[i] = 32'(10 * (i + 1));
      sb.push_back(pre_val[i]);
      fv[i] = 32'(i + 1);
    end
    preload_req = 1'b1;
    @(posedge clk);
    #1 preload_req = 1'b0;
    kwr = 1'b0;
    acc_cyc.delete();
    log_en = 1'b1;
    send_frame(fv);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ap_start && t < 20);
    ap_cyc = cyc;
    log_en = 1'b0;
    chk_eq("ap_start_seen", ap_start, 1);
    chk_eq("img_wr_count", wr_cyc.size(), N);
    if (wr_cyc.size() == N) begin
      for (int i = 0; i < N; i++) begin
        chk_eq("img_wr_addr", wr_addr[i], i);
        chk_eq("img_wr_data", wr_data[i], fv[i]);
        chk_eq("img_wr_cycle", wr_cyc[i], wr_cyc[0] + i);
      end
      chk_eq("ap_start_cycle", ap_cyc, wr_cyc[N-1] + 1);
    end
    wait_idle();
    chk_eq("drain_beats", acc_cyc.size(), N);
    if (acc_cyc.size() == N)
      for (int i = 1; i < N; i++)
        chk_eq("drain_b2b", acc_cyc[i], acc_cyc[0] + i);

    // Random frames, kernel writes mask, random out_ready
    kwr       = 1'b1;
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_frame(fv, 1'b1);
      send_frame(fv);
      wait_idle();
    end
    rnd_ready = 1'b0;
    ready_fixed = 1'b1;

    // Kernel never finishes: RUN timeout
    done_at = 0;
    rand_frame(fv, 1'b0);
    send_frame(fv);
    run_cycles = 0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (!ap_start && busy) run_cycles++;
    end while (busy && t < 200);
    chk_eq("timeout_run_cycles", run_cycles, 50);
    chk_eq("timeout_err_set", timeout_err, 1);
    chk_eq("timeout_busy", busy, 0);
    @(posedge clk);
    #1 kabort = 1'b1;
    @(posedge clk);
    #1 kabort = 1'b0;
    done_at = 20;

    // Reset in the middle of DRAIN, then a fresh frame
    rand_frame(fv, 1'b1);
    send_frame(fv);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(out_valid && out_ready) && t < 300);
    chk_eq("drain_started", out_valid && out_ready, 1);
    chk_eq("timeout_sticky", timeout_err, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_fixed = 1'b0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk_reset_outs();
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    ready_fixed = 1'b1;
    @(negedge clk);
    chk_eq("post_rst_timeout_err", timeout_err, 0);
    rand_frame(fv, 1'b1);
    send_frame(fv);
    wait_idle();

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
